wb_spi_initiator: RTL and testbench
===================================

// Module: wb_spi_initiator
// PURPOSE
//  Wishbone B4 classic slave that turns each single-beat access into one SPI frame in the
//  host-side command format that the chip's SPI-to-Wishbone bridge decodes. It is the host
//  end of that link: FPGA test harnesses and chained chips use it to read and write the
//  remote 23-bit address space (SRAM and controller registers) over four wires.
// PARAMETERS
//  ADDR_WIDTH  23  Wishbone address width; must be <=23; zero-extended into the frame
//  CLK_DIV     2   clk_i cycles per SCK half-period (>=1)
//  WAIT_BITS   8   dummy SCK cycles between header and read data (remote turnaround)
// PORTS
//  clk_i      in   1           clock; all logic on rising edge
//  rst_n      in   1           asynchronous active-low reset
//  cyc_i      in   1           Wishbone cycle
//  stb_i      in   1           Wishbone strobe
//  adr_i      in   ADDR_WIDTH  remote byte address
//  we_i       in   1           1=write, 0=read
//  dat_i      in   8           write data
//  ack_o      out  1           one-cycle transfer complete
//  err_o      out  1           tied 0
//  rty_o      out  1           tied 0
//  dat_o      out  8           read data, held until the next read completes
//  busy_o     out  1           high from request capture until GAP ends
//  spi_ss_n   out  1           frame select, active low
//  spi_sck    out  1           SPI clock, mode 0 (idle low)
//  spi_mosi   out  1           serial out, MSB first
//  spi_miso   in   1           serial in, MSB first
// BEHAVIOUR
//  - Reset: ss_n=1, sck=0, mosi=0, ack_o=0, dat_o=0, busy_o=0, state IDLE; async assert, sync release.
//  - Frame: 24-bit header {we, adr[22:0]}, then write: 8 bits dat_i; read: WAIT_BITS zero
//    bits on MOSI, then 8 bits sampled from MISO. MSB first throughout.
//  - States: IDLE -> SETUP -> HEADER -> (we ? WDATA : WAIT -> RDATA) -> DONE -> GAP -> IDLE.
//  - IDLE: on cyc_i&stb_i&!ack_o, latch adr/we/dat into a 40-bit shift register; next
//    cycle ss_n=0, mosi=header bit 23. SETUP lasts CLK_DIV cycles with sck low.
//  - Each bit: CLK_DIV cycles sck low (mosi stable), CLK_DIV cycles sck high; MISO sampled
//    on the cycle sck goes high; mosi changes only on the cycle sck goes low.
//  - Bit counter 6 bits; header=24, WDATA=8, WAIT=WAIT_BITS (state skipped if 0), RDATA=8.
//  - After the last bit's high half: sck=0, ss_n=1, mosi=0 (DONE, 1 cycle); ack_o pulses
//    in DONE; dat_o updated in the same cycle for reads.
//  - Latency request-capture-edge to ack: write CLK_DIV+64*CLK_DIV+1; read
//    CLK_DIV+(32+WAIT_BITS)*2*CLK_DIV+1 (131 / 163 at defaults).
//  - GAP: ss_n held high CLK_DIV cycles before a new request is accepted; stb_i held high
//    through GAP after ack is a new request only if the master re-presents it after ack.
//  - Abort: cyc_i low in SETUP..RDATA -> next cycle ss_n=1, sck=0, mosi=0, go GAP, no ack,
//    dat_o unchanged. stb_i alone dropping mid-frame is ignored (frame completes, ack given).
//  - adr_i/dat_i/we_i changes after capture have no effect on the frame in progress.
//  - rst_n asserted mid-frame: immediate return to reset values; no partial ack.
// TESTING
//  1 Write 0x5A to 0x012345, CLK_DIV=2 -> MOSI 0x812345 then 0x5A, 32 SCK rising edges,
//    ack_o single pulse 131 cycles after capture, ss_n high in that cycle.
//  2 Read 0x000010, MISO model drives 0xC3 after 8 dummy bits -> MOSI 0x000010 + 8 zeros,
//    dat_o=0xC3 with ack at cycle 163; dat_o still 0xC3 after a following write.
//  3 Back-to-back write then read with stb_i re-raised the cycle after ack -> ss_n high
//    >=CLK_DIV cycles between frames, both acks, correct data.
//  4 Drop cyc_i at header bit 10 -> ss_n high next cycle, sck low, no ack, busy_o clears
//    after GAP; following read completes normally.
//  5 Assert rst_n low at WDATA bit 3 -> outputs at reset values asynchronously; no ack.
//  6 CLK_DIV=1, WAIT_BITS=0 read of 0x7FFFFF -> sck toggles every cycle, header
//    0x7FFFFF, data bits directly follow, ack at cycle 1+64+1=66.

Source files
------------

// File: rtl/wb_spi_initiator_if.sv
// Wishbone B4 classic single-beat bus between a host master and wb_spi_initiator.
// Signal suffixes follow the slave's point of view.
interface wb_spi_initiator_if #(
    parameter int unsigned ADDR_WIDTH = 23
) ();
    logic                  cyc_i;
    logic                  stb_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic                  we_i;
    logic [7:0]            dat_i;
    logic                  ack_o;
    logic                  err_o;
    logic                  rty_o;
    logic [7:0]            dat_o;

    modport master (
        output cyc_i, stb_i, adr_i, we_i, dat_i,
        input  ack_o, err_o, rty_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, adr_i, we_i, dat_i,
        output ack_o, err_o, rty_o, dat_o
    );
endinterface

// File: rtl/wb_spi_initiator.sv
// Wishbone slave that turns each single-beat access into one SPI mode-0 frame:
// 24-bit header {we, adr}, then 8 write bits, or WAIT_BITS dummy bits plus 8 read bits.
module wb_spi_initiator #(
    parameter int unsigned ADDR_WIDTH = 23,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned WAIT_BITS  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n,
    wb_spi_initiator_if.slave wb,
    output logic              busy_o,
    output logic              spi_ss_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StSetup  = 3'd1;
    localparam logic [2:0] StHeader = 3'd2;
    localparam logic [2:0] StWdata  = 3'd3;
    localparam logic [2:0] StWait   = 3'd4;
    localparam logic [2:0] StRdata  = 3'd5;
    localparam logic [2:0] StDone   = 3'd6;
    localparam logic [2:0] StGap    = 3'd7;

    localparam int unsigned   DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [2:0]      state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic            sck_q, sck_d;
    logic            ss_n_q, ss_n_d;
    logic [39:0]     sh_q, sh_d;
    logic [5:0]      bit_q, bit_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      dat_q, dat_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            we_q, we_d;
    logic [22:0]     adr_ext;
    logic            in_frame;

    always_comb begin
        adr_ext = 23'(wb.adr_i[ADDR_WIDTH-1:0]);
    end

    assign in_frame = (state_q == StSetup) || (state_q == StHeader) || (state_q == StWdata) ||
                      (state_q == StWait) || (state_q == StRdata);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sck_d   = sck_q;
        ss_n_d  = ss_n_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        we_d    = we_q;

        case (state_q)
            StIdle: begin
                if (wb.cyc_i && wb.stb_i && !ack_q) begin
                    state_d = StSetup;
                    div_d   = '0;
                    ss_n_d  = 1'b0;
                    we_d    = wb.we_i;
                    sh_d    = {wb.we_i, adr_ext, (wb.we_i ? wb.dat_i : 8'h00), 8'h00};
                    bit_d   = 6'd24;
                    busy_d  = 1'b1;
                end
            end
            StSetup: begin
                if (div_q == DivLast) begin
                    state_d = StHeader;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StHeader, StWdata, StWait, StRdata: begin
                if (div_q != DivLast) begin
                    div_d = div_q + 1'b1;
                end else if (!sck_q) begin
                    // Rising edge: the remote drives MISO on the falling edge, so sample here.
                    div_d = '0;
                    sck_d = 1'b1;
                    if (state_q == StRdata) rx_d = {rx_q[6:0], spi_miso};
                end else begin
                    div_d = '0;
                    sck_d = 1'b0;
                    sh_d  = {sh_q[38:0], 1'b0};
                    bit_d = bit_q - 6'd1;
                    if (bit_q == 6'd1) begin
                        case (state_q)
                            StHeader: begin
                                if (we_q) begin
                                    state_d = StWdata;
                                    bit_d   = 6'd8;
                                end else if (WAIT_BITS != 0) begin
                                    state_d = StWait;
                                    bit_d   = 6'(WAIT_BITS);
                                end else begin
                                    state_d = StRdata;
                                    bit_d   = 6'd8;
                                end
                            end
                            StWait: begin
                                state_d = StRdata;
                                bit_d   = 6'd8;
                            end
                            default: begin
                                state_d = StDone;
                                ss_n_d  = 1'b1;
                                sh_d    = '0;
                                ack_d   = 1'b1;
                                if (!we_q) dat_d = rx_q;
                            end
                        endcase
                    end
                end
            end
            StDone: begin
                state_d = StGap;
                div_d   = '0;
            end
            StGap: begin
                if (div_q == DivLast) begin
                    state_d = StIdle;
                    div_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Losing cyc_i mid-frame abandons the frame; stb_i alone is not consulted here.
        if (in_frame && !wb.cyc_i) begin
            state_d = StGap;
            div_d   = '0;
            sck_d   = 1'b0;
            ss_n_d  = 1'b1;
            sh_d    = '0;
            ack_d   = 1'b0;
            dat_d   = dat_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            sck_q   <= 1'b0;
            ss_n_q  <= 1'b1;
            sh_q    <= '0;
            bit_q   <= '0;
            rx_q    <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sck_q   <= sck_d;
            ss_n_q  <= ss_n_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.err_o = 1'b0;
    assign wb.rty_o = 1'b0;
    assign wb.dat_o = dat_q;
    assign busy_o   = busy_q;
    assign spi_ss_n = ss_n_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = sh_q[39];

endmodule

// File: tb/tb_wb_spi_initiator.sv
// Bench for wb_spi_initiator: dut0 at defaults (CLK_DIV=2, WAIT_BITS=8), dut1 at CLK_DIV=1,
// WAIT_BITS=0; an SPI remote model captures MOSI and serves MISO bytes.
module tb_wb_spi_initiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    wb_spi_initiator_if #(.ADDR_WIDTH(23)) wb0 ();
    wb_spi_initiator_if #(.ADDR_WIDTH(23)) wb1 ();

    logic [1:0] busy, ss_n, sck, mosi, miso;

    wb_spi_initiator #(.ADDR_WIDTH(23), .CLK_DIV(2), .WAIT_BITS(8)) u_dut0 (
        .clk_i(clk), .rst_n(rst_n), .wb(wb0), .busy_o(busy[0]), .spi_ss_n(ss_n[0]),
        .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
    );

    wb_spi_initiator #(.ADDR_WIDTH(23), .CLK_DIV(1), .WAIT_BITS(0)) u_dut1 (
        .clk_i(clk), .rst_n(rst_n), .wb(wb1), .busy_o(busy[1]), .spi_ss_n(ss_n[1]),
        .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic int wbits(input int d);
        return (d == 0) ? 8 : 0;
    endfunction

    function automatic int cdiv(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Remote model state, updated 1 time unit after each rising edge.
    int          rise_cnt [2] = '{0, 0};
    int          gap_cnt  [2] = '{0, 0};
    int          last_gap [2] = '{0, 0};
    int          first_rise [2] = '{0, 0};
    int          last_rise  [2] = '{0, 0};
    int          cyc_cnt = 0;
    logic [63:0] cap [2] = '{64'h0, 64'h0};
    logic [7:0]  miso_byte [2] = '{8'h00, 8'h00};
    logic [1:0]  ss_prev = 2'b11;
    logic [1:0]  sck_prev = 2'b00;

    always @(posedge clk) begin
        #1;
        cyc_cnt++;
        for (int d = 0; d < 2; d++) begin
            if (ss_n[d]) gap_cnt[d]++;
            if (ss_prev[d] && !ss_n[d]) begin
                last_gap[d] = gap_cnt[d];
                gap_cnt[d]  = 0;
                rise_cnt[d] = 0;
                cap[d]      = 64'h0;
            end
            if (!ss_n[d] && sck[d] && !sck_prev[d]) begin
                if (rise_cnt[d] == 0) first_rise[d] = cyc_cnt;
                last_rise[d] = cyc_cnt;
                rise_cnt[d]++;
                cap[d] = {cap[d][62:0], mosi[d]};
            end
            ss_prev[d]  = ss_n[d];
            sck_prev[d] = sck[d];
        end
    end

    // Read byte occupies rises 24+W .. 31+W, MSB first.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            miso[d] = 1'b0;
            if (rise_cnt[d] >= 24 + wbits(d) && rise_cnt[d] < 32 + wbits(d))
                miso[d] = miso_byte[d][3'(31 + wbits(d) - rise_cnt[d])];
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int d, input logic c, input logic s, input logic we,
                           input logic [22:0] adr, input logic [7:0] wd);
        if (d == 0) begin
            wb0.cyc_i = c; wb0.stb_i = s; wb0.we_i = we; wb0.adr_i = adr; wb0.dat_i = wd;
        end else begin
            wb1.cyc_i = c; wb1.stb_i = s; wb1.we_i = we; wb1.adr_i = adr; wb1.dat_i = wd;
        end
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? wb0.ack_o : wb1.ack_o;
    endfunction

    function automatic logic [7:0] get_dat(input int d);
        return (d == 0) ? wb0.dat_o : wb1.dat_o;
    endfunction

    task automatic wait_capture(input int d, output bit got);
        logic pb;
        pb  = busy[d];
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #2;
            if (busy[d] && !pb) got = 1'b1;
            pb = busy[d];
        end
    endtask

    // One full access; lat counts cycles with the first cycle after capture as 1.
    task automatic do_xfer(input int d, input logic we, input logic [22:0] adr,
                           input logic [7:0] wd, input logic [7:0] mb, input logic [7:0] exp_dat,
                           input int exp_lat, input string nm);
        bit          got;
        int          lat;
        int          nb;
        logic [63:0] exp_cap;
        miso_byte[d] = mb;
        set_req(d, 1'b1, 1'b1, we, adr, wd);
        wait_capture(d, got);
        check({nm, " capture"}, 64'(got), 64'd1);
        if (!got) begin
            set_req(d, 1'b0, 1'b0, we, adr, wd);
            return;
        end
        set_req(d, 1'b1, 1'b0, ~we, ~adr, ~wd);
        lat = 1;
        for (int i = 0; i < 400 && !get_ack(d); i++) begin
            @(posedge clk); #2;
            lat++;
        end
        nb      = we ? 32 : 32 + wbits(d);
        exp_cap = we ? {32'h0, we, adr, wd} : ({40'h0, we, adr} << (wbits(d) + 8));
        check({nm, " ack latency"}, 64'(lat), 64'(exp_lat));
        check({nm, " ss_n at ack"}, 64'(ss_n[d]), 64'd1);
        check({nm, " sck rises"}, 64'(rise_cnt[d]), 64'(nb));
        check({nm, " mosi frame"}, cap[d], exp_cap);
        check({nm, " dat_o"}, 64'(get_dat(d)), 64'(exp_dat));
        check({nm, " ss_n gap"}, 64'(last_gap[d] >= cdiv(d) + 1), 64'd1);
        set_req(d, 1'b0, 1'b0, we, adr, wd);
        @(posedge clk); #2;
        check({nm, " ack one cycle"}, 64'(get_ack(d)), 64'd0);
    endtask

    typedef struct {
        logic        we;
        logic [22:0] adr;
        logic [7:0]  wd;
        logic [7:0]  mb;
        logic [7:0]  exp_dat;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        bit   got;
        bit   ack_seen;
        int   n;

        vecs[0] = '{1'b1, 23'h012345, 8'h5A, 8'h00, 8'h00, 131};
        vecs[1] = '{1'b0, 23'h000010, 8'h00, 8'hC3, 8'hC3, 163};
        vecs[2] = '{1'b1, 23'h7FFFFF, 8'hA5, 8'h00, 8'hC3, 131};
        vecs[3] = '{1'b0, 23'h2AAAAA, 8'h00, 8'h5A, 8'h5A, 163};
        vecs[4] = '{1'b1, 23'h000000, 8'hFF, 8'h00, 8'h5A, 131};

        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 1'b0, 23'h0, 8'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 23'h0, 8'h0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        check("reset ss_n", 64'(ss_n[0]), 64'd1);
        check("reset sck", 64'(sck[0]), 64'd0);
        check("reset mosi", 64'(mosi[0]), 64'd0);
        check("reset ack", 64'(wb0.ack_o), 64'd0);
        check("reset dat_o", 64'(wb0.dat_o), 64'd0);
        check("reset busy", 64'(busy[0]), 64'd0);
        check("reset err/rty", 64'({wb0.err_o, wb0.rty_o}), 64'd0);

        // Back-to-back: each access is presented the cycle after the previous ack.
        for (int i = 0; i < 5; i++)
            do_xfer(0, vecs[i].we, vecs[i].adr, vecs[i].wd, vecs[i].mb, vecs[i].exp_dat,
                    vecs[i].exp_lat, $sformatf("vec%0d", i));

        // Abort a read at header bit 10 while MOSI is high.
        set_req(0, 1'b1, 1'b1, 1'b0, 23'h7FFFFF, 8'h00);
        wait_capture(0, got);
        check("abort capture", 64'(got), 64'd1);
        for (int i = 0; i < 200 && rise_cnt[0] < 10; i++) begin
            @(posedge clk); #2;
        end
        check("abort reached bit 10", 64'(rise_cnt[0]), 64'd10);
        check("abort mosi before", 64'(mosi[0]), 64'd1);
        set_req(0, 1'b0, 1'b0, 1'b0, 23'h7FFFFF, 8'h00);
        @(posedge clk); #2;
        check("abort ss_n", 64'(ss_n[0]), 64'd1);
        check("abort sck", 64'(sck[0]), 64'd0);
        check("abort mosi", 64'(mosi[0]), 64'd0);
        ack_seen = 1'b0;
        got      = 1'b0;
        n        = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (wb0.ack_o) ack_seen = 1'b1;
            if (!busy[0]) got = 1'b1;
            else begin
                @(posedge clk); #2;
                n++;
            end
        end
        check("abort busy clears", 64'(got), 64'd1);
        check("abort gap cycles", 64'(n), 64'd2);
        check("abort no ack", 64'(ack_seen), 64'd0);
        check("abort dat_o kept", 64'(wb0.dat_o), 64'h5A);
        do_xfer(0, 1'b0, 23'h000123, 8'h00, 8'h3C, 8'h3C, 163, "post-abort read");

        // Reset in the high half of write data bit 3.
        set_req(0, 1'b1, 1'b1, 1'b1, 23'h012345, 8'hFF);
        wait_capture(0, got);
        for (int i = 0; i < 300 && rise_cnt[0] < 28; i++) begin
            @(posedge clk); #2;
        end
        check("reset-mid sck high", 64'(sck[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("reset-mid ss_n", 64'(ss_n[0]), 64'd1);
        check("reset-mid sck", 64'(sck[0]), 64'd0);
        check("reset-mid mosi", 64'(mosi[0]), 64'd0);
        check("reset-mid busy", 64'(busy[0]), 64'd0);
        check("reset-mid dat_o", 64'(wb0.dat_o), 64'd0);
        set_req(0, 1'b0, 1'b0, 1'b0, 23'h0, 8'h0);
        ack_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            if (wb0.ack_o) ack_seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            if (wb0.ack_o) ack_seen = 1'b1;
        end
        check("reset-mid no ack", 64'(ack_seen), 64'd0);

        // CLK_DIV=1, WAIT_BITS=0: SCK toggles every cycle, data follows header directly.
        do_xfer(1, 1'b0, 23'h7FFFFF, 8'h00, 8'h96, 8'h96, 66, "fast read");
        check("fast sck spacing", 64'(last_rise[1] - first_rise[1]), 64'd62);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
